// File: rtl/conv_pkg.sv
// Shared conv datapath constants and the requantisation stage record.
package conv_pkg;
    localparam int ACC_WIDTH   = 48;
    localparam int PIXEL_WIDTH = 16;
    localparam int LANES       = 4;
    localparam int LANE_W      = $clog2(LANES);
    localparam int PIX_MAX     = 2 ** (PIXEL_WIDTH - 1) - 1;
    localparam int PIX_MIN     = -(2 ** (PIXEL_WIDTH - 1));

    typedef logic [PIXEL_WIDTH-1:0] pix_t;

    typedef struct packed {
        pix_t pix;
        logic last;
        logic sat;
        logic valid;
    } r_stage_t;
endpackage

// File: rtl/requant_leaky.sv
// Combinational LeakyReLU plus round/shift/saturate of a signed accumulator to one pixel.
module requant_leaky
    import conv_pkg::*;
#(
    parameter int FRAC_BITS   = 8,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic                        relu_en,
    output logic [PIXEL_WIDTH-1:0]      pix,
    output logic                        sat
);
    localparam logic signed [ACC_WIDTH:0] ROUND = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [ACC_WIDTH:0] Q_MAX = (ACC_WIDTH + 1)'(PIX_MAX);
    localparam logic signed [ACC_WIDTH:0] Q_MIN = (ACC_WIDTH + 1)'(PIX_MIN);

    logic signed [ACC_WIDTH:0] a;
    logic signed [ACC_WIDTH:0] q;

    // One guard bit keeps the rounding add from overflowing at the extremes.
    always_comb begin
        a = {acc[ACC_WIDTH-1], acc};
        if (relu_en && acc[ACC_WIDTH-1]) a = a >>> LEAKY_SHIFT;
        q   = (a + ROUND) >>> FRAC_BITS;
        pix = q[PIXEL_WIDTH-1:0];
        sat = 1'b0;
        if (q > Q_MAX) begin
            pix = Q_MAX[PIXEL_WIDTH-1:0];
            sat = 1'b1;
        end else if (q < Q_MIN) begin
            pix = Q_MIN[PIXEL_WIDTH-1:0];
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/conv_output_packer.sv
// Requantises the accumulator stream and packs LANES pixels per AXI-Stream output beat.
module conv_output_packer
    import conv_pkg::*;
#(
    parameter int FRAC_BITS   = 8,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     relu_en,
    input  logic                     clr_stats,
    input  logic [63:0]              s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [LANES*PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic [2*LANES-1:0]       m_axis_tkeep,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [15:0]              sat_count,
    output logic                     idle
);
    r_stage_t                                r_q, r_d;
    logic [LANES-2:0][PIXEL_WIDTH-1:0]       pack_q, pack_d;
    logic [LANE_W-1:0]                       lane_cnt_q, lane_cnt_d;
    logic [LANES-1:0][PIXEL_WIDTH-1:0]       m_data_q, m_data_d;
    logic [2*LANES-1:0]                      m_keep_q, m_keep_d;
    logic                                    m_last_q, m_last_d;
    logic                                    m_valid_q, m_valid_d;
    logic [15:0]                             sat_count_q, sat_count_d;

    pix_t in_pix;
    logic in_sat;
    logic completes, drain, accept;
    logic unused_tdata;

    assign unused_tdata = ^s_axis_tdata[63:ACC_WIDTH];

    requant_leaky #(.FRAC_BITS(FRAC_BITS), .LEAKY_SHIFT(LEAKY_SHIFT)) u_requant (
        .acc     (s_axis_tdata[ACC_WIDTH-1:0]),
        .relu_en (relu_en),
        .pix     (in_pix),
        .sat     (in_sat)
    );

    always_comb begin
        r_d         = r_q;
        pack_d      = pack_q;
        lane_cnt_d  = lane_cnt_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q;
        sat_count_d = sat_count_q;

        completes = (lane_cnt_q == LANE_W'(LANES - 1)) || r_q.last;
        // A completing pixel can only leave R if the output register is free this cycle.
        drain         = r_q.valid && !(completes && m_valid_q && !m_axis_tready);
        s_axis_tready = rst_n && (!r_q.valid || drain);
        accept        = s_axis_tvalid && s_axis_tready;

        if (accept) r_d = '{pix: in_pix, last: s_axis_tlast, sat: in_sat, valid: 1'b1};
        else if (drain) r_d.valid = 1'b0;

        if (m_axis_tready) m_valid_d = 1'b0;

        if (drain) begin
            if (!completes) begin
                pack_d[lane_cnt_q] = r_q.pix;
                lane_cnt_d         = lane_cnt_q + LANE_W'(1);
            end else begin
                m_data_d = '0;
                m_keep_d = '0;
                for (int i = 0; i < LANES - 1; i++)
                    if (i < int'(lane_cnt_q)) m_data_d[i] = pack_q[i];
                m_data_d[lane_cnt_q] = r_q.pix;
                for (int i = 0; i < LANES; i++)
                    if (i <= int'(lane_cnt_q)) m_keep_d[2*i +: 2] = 2'b11;
                m_last_d   = r_q.last;
                m_valid_d  = 1'b1;
                lane_cnt_d = '0;
            end
        end

        if (clr_stats) sat_count_d = '0;
        else if (drain && r_q.sat && sat_count_q != 16'hFFFF) sat_count_d = sat_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            pack_q      <= '0;
            lane_cnt_q  <= '0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            r_q         <= r_d;
            pack_q      <= pack_d;
            lane_cnt_q  <= lane_cnt_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_last_q    <= m_last_d;
            m_valid_q   <= m_valid_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tvalid = m_valid_q;
    assign sat_count     = sat_count_q;
    assign idle          = !r_q.valid && (lane_cnt_q == '0) && !m_valid_q;
endmodule

// File: tb/tb_conv_output_packer.sv
// Vector table, corner sequences and randomized scoreboard for conv_output_packer.
`timescale 1ns/1ps
module tb_conv_output_packer;
    logic        clk = 1'b0;
    logic        rst_n, relu_en, clr_stats;
    logic [63:0] s_data;
    logic        s_valid, s_last, s_ready;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic        m_valid, m_last, m_ready;
    logic [15:0] sat_count;
    logic        idle;

    always #5 clk = ~clk;

    conv_output_packer dut (
        .clk(clk), .rst_n(rst_n), .relu_en(relu_en), .clr_stats(clr_stats),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
        .s_axis_tready(s_ready), .m_axis_tdata(m_data), .m_axis_tkeep(m_keep),
        .m_axis_tvalid(m_valid), .m_axis_tlast(m_last), .m_axis_tready(m_ready),
        .sat_count(sat_count), .idle(idle)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] pend[$];
    int          exp_sat = 0;
    int          beat_cnt = 0;
    beat_t       got_beat, mb, me;
    logic [16:0] mp;

    function automatic longint floordiv(longint x, longint d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    // Returns {sat, pix}: leaky slope 1/8, round to nearest, divide by 256, clamp to int16.
    function automatic logic [16:0] ref_pix(input logic [47:0] raw, input logic relu);
        longint a, q;
        logic [63:0] qb;
        logic s;
        a = longint'($signed(raw));
        if (relu && a < 0) a = floordiv(a, 8);
        q = floordiv(a + 128, 256);
        s = 1'b0;
        if (q > 32767) begin q = 32767; s = 1'b1; end
        if (q < -32768) begin q = -32768; s = 1'b1; end
        qb = q;
        return {s, qb[15:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            exp_q.delete();
            exp_sat = 0;
        end else begin
            if (clr_stats) exp_sat = 0;
            if (s_valid && s_ready) begin
                mp = ref_pix(s_data[47:0], relu_en);
                if (mp[16] && exp_sat < 65535) exp_sat++;
                pend.push_back(mp[15:0]);
                if (pend.size() == 4 || s_last) begin
                    mb.data = '0;
                    for (int i = 0; i < pend.size(); i++) mb.data[16*i +: 16] = pend[i];
                    mb.keep = 8'((1 << (2 * pend.size())) - 1);
                    mb.last = s_last;
                    exp_q.push_back(mb);
                    pend.delete();
                end
            end
            if (m_valid && m_ready) begin
                got_beat.data = m_data;
                got_beat.keep = m_keep;
                got_beat.last = m_last;
                beat_cnt++;
                if (exp_q.size() == 0) check("beat_unexpected", 64'd1, 64'd0);
                else begin
                    me = exp_q.pop_front();
                    check("beat_data", m_data, me.data);
                    check("beat_keep", {56'd0, m_keep}, {56'd0, me.keep});
                    check("beat_last", {63'd0, m_last}, {63'd0, me.last});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [47:0] acc, input logic last);
        bit done = 0;
        s_data  = {16'hA5A5, acc};
        s_last  = last;
        s_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_beat(input int start);
        for (int k = 0; k < 30 && beat_cnt == start; k++) tick();
        check("beat_seen", {63'd0, beat_cnt != start}, 64'd1);
    endtask

    function automatic logic [63:0] rand_acc();
        longint v;
        logic [63:0] r;
        case ($urandom_range(0, 3))
            0: v = longint'($urandom_range(0, 200000)) - 100000;
            1: v = longint'($urandom_range(0, 32'h0200_0000)) - 64'sh0100_0000;
            2: begin
                r = {$urandom, $urandom};
                return r;
            end
            default: v = longint'($urandom_range(0, 511)) - 256 +
                         (($urandom_range(0, 1) == 1) ? 64'sh7F_FF80 : -64'sh80_0080);
        endcase
        r = v;
        r[63:48] = 16'($urandom);
        return r;
    endfunction

    typedef struct {
        logic              relu;
        int                n;
        logic [3:0][47:0]  acc;
        logic [63:0]       data;
        logic [7:0]        keep;
        int                sat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int start, accepts;
        bit a;

        vecs[0] = '{1'b0, 4, {48'h7F, 48'hFFFF_FFFF_FF00, 48'h200, 48'h100}, 64'h0000_FFFF_0002_0001, 8'hFF, 0};
        vecs[1] = '{1'b1, 4, {48'h80, 48'hFFFF_FFFF_FFF8, 48'h300, 48'hFFFF_FFFF_F800}, 64'h0001_0000_0003_FFFF, 8'hFF, 0};
        vecs[2] = '{1'b0, 1, {48'h0, 48'h0, 48'h0, 48'hFFFF_FFFF_F800}, 64'h0000_0000_0000_FFF8, 8'h03, 0};
        vecs[3] = '{1'b0, 2, {48'h0, 48'h0, 48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF}, 64'h0000_0000_8000_7FFF, 8'h0F, 2};
        vecs[4] = '{1'b0, 2, {48'h0, 48'h0, 48'h200, 48'h100}, 64'h0000_0000_0002_0001, 8'h0F, 2};
        vecs[5] = '{1'b1, 3, {48'h0, 48'h300, 48'h200, 48'h100}, 64'h0000_0003_0002_0001, 8'h3F, 2};
        vecs[6] = '{1'b0, 4, {48'hFFFF_FF7F_FF80, 48'h7F_FF80, 48'hFFFF_FFFF_FF80, 48'h180}, 64'h8000_7FFF_0000_0002, 8'hFF, 3};

        rst_n = 1'b0; relu_en = 1'b0; clr_stats = 1'b0;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_s_ready", {63'd0, s_ready}, 64'd0);
        check("rst_idle", {63'd0, idle}, 64'd1);
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_m_keep", {56'd0, m_keep}, 64'd0);
        check("rst_m_last", {63'd0, m_last}, 64'd0);
        check("rst_sat", {48'd0, sat_count}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Directed vectors, one packed beat each, with one-cycle latency check.
        for (int v = 0; v < 7; v++) begin
            relu_en = vecs[v].relu;
            tick();
            start = beat_cnt;
            for (int j = 0; j < vecs[v].n; j++) send(vecs[v].acc[j], j == vecs[v].n - 1);
            @(negedge clk);
            check("lat_hold", {63'd0, m_valid}, 64'd0);
            @(negedge clk);
            check("lat_out", {63'd0, m_valid}, 64'd1);
            tick();
            wait_beat(start);
            check("vec_data", got_beat.data, vecs[v].data);
            check("vec_keep", {56'd0, got_beat.keep}, {56'd0, vecs[v].keep});
            check("vec_last", {63'd0, got_beat.last}, 64'd1);
            check("vec_sat", {48'd0, sat_count}, 64'(vecs[v].sat));
            check("vec_idle", {63'd0, idle}, 64'd1);
        end

        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_sat", {48'd0, sat_count}, 64'd0);

        // Clear coincides with a saturating drain.
        send(48'h7FFF_FFFF_FFFF, 1'b1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_wins", {48'd0, sat_count}, 64'd0);
        repeat (3) tick();
        check("clr_wins_hold", {48'd0, sat_count}, 64'd0);

        // Backpressure: downstream stalled, upstream continuous.
        m_ready = 1'b0;
        tick();
        accepts = 0;
        s_last  = 1'b0;
        s_data  = rand_acc();
        s_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            a = s_ready;
            if (a) accepts++;
            @(posedge clk); #1;
            if (a) s_data = rand_acc();
        end
        s_valid = 1'b0;
        @(negedge clk);
        check("bp_accepts", 64'(accepts), 64'd8);
        check("bp_s_ready", {63'd0, s_ready}, 64'd0);
        check("bp_m_valid", {63'd0, m_valid}, 64'd1);
        check("bp_queued", 64'(exp_q.size()), 64'd2);
        if (exp_q.size() > 0) check("bp_tdata_stable", m_data, exp_q[0].data);
        @(posedge clk); #1;
        start = beat_cnt;
        m_ready = 1'b1;
        for (int k = 0; k < 20 && beat_cnt - start < 2; k++) tick();
        tick();
        check("bp_drained", 64'(beat_cnt - start), 64'd2);
        check("bp_idle", {63'd0, idle}, 64'd1);

        // Reset in the middle of a partial pack.
        send(48'h500, 1'b0);
        send(48'h600, 1'b0);
        tick();
        tick();
        start = beat_cnt;
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid", {63'd0, m_valid}, 64'd0);
        check("mid_rst_data", m_data, 64'd0);
        check("mid_rst_keep", {56'd0, m_keep}, 64'd0);
        check("mid_rst_ready", {63'd0, s_ready}, 64'd0);
        check("mid_rst_idle", {63'd0, idle}, 64'd1);
        check("mid_rst_sat", {48'd0, sat_count}, 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        check("mid_rst_no_beat", 64'(beat_cnt - start), 64'd0);
        start = beat_cnt;
        send(48'h100, 1'b0);
        send(48'h200, 1'b0);
        send(48'h300, 1'b0);
        send(48'h400, 1'b0);
        wait_beat(start);
        check("post_rst_data", got_beat.data, 64'h0004_0003_0002_0001);
        check("post_rst_keep", {56'd0, got_beat.keep}, 64'hFF);
        check("post_rst_last", {63'd0, got_beat.last}, 64'd0);

        // Randomized traffic against the scoreboard, once per relu mode.
        for (int ph = 0; ph < 2; ph++) begin
            int sent = 0;
            bit acc_now;
            relu_en = ph[0];
            tick();
            s_valid = 1'b0;
            for (int c = 0; c < 4000 && !(sent == 200 && !s_valid); c++) begin
                @(negedge clk);
                acc_now = s_valid && s_ready;
                @(posedge clk); #1;
                m_ready = ($urandom_range(0, 3) != 0);
                if (!s_valid || acc_now) begin
                    if (sent < 200 && $urandom_range(0, 4) != 0) begin
                        s_data  = rand_acc();
                        s_last  = (sent == 199) || ($urandom_range(0, 5) == 0);
                        s_valid = 1'b1;
                        sent++;
                    end else begin
                        s_valid = 1'b0;
                        s_last  = 1'b0;
                    end
                end
            end
            check("rand_all_sent", 64'(sent), 64'd200);
            s_valid = 1'b0;
            s_last  = 1'b0;
            m_ready = 1'b1;
            for (int k = 0; k < 50 && !idle; k++) tick();
            tick();
            check("rand_idle", {63'd0, idle}, 64'd1);
            check("rand_queue_empty", 64'(exp_q.size() + pend.size()), 64'd0);
            check("rand_sat", {48'd0, sat_count}, 64'(exp_sat));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
